// File: rtl/rv32_alu_pkg.sv
// rtl/rv32_alu_pkg.sv - shared types and constants for the multicycle ALU
// Purpose: operation encodings, FSM state type and datapath width used by
//          rv32_alu_multicycle_unit and rv32_alu_chunk_slice.
// Ports:   none (package).
package rv32_alu_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      COMPUTE = 2'b01,
      DONE    = 2'b10
   } alu_fsm_state_e;

endpackage

// File: rtl/rv32_alu_chunk_slice.sv
// rtl/rv32_alu_chunk_slice.sv - combinational CHUNK_W-bit ALU slice
// Purpose: computes one chunk of the ALU result and the carry into the next chunk.
// Ports:
//   a, b     CHUNK_W-bit operand slices
//   op       2-bit operation select (alu_op_e encoding)
//   cin      carry into this slice
//   res      CHUNK_W-bit result slice
//   cout     carry out of this slice (0 for AND/OR)
module rv32_alu_chunk_slice
   import rv32_alu_pkg::*;
#(
   parameter int CHUNK_W = 8
) (
   input  logic [CHUNK_W-1:0] a,
   input  logic [CHUNK_W-1:0] b,
   input  logic [1:0]         op,
   input  logic               cin,
   output logic [CHUNK_W-1:0] res,
   output logic               cout
);

   logic [CHUNK_W:0] sum;
   logic [CHUNK_W-1:0] b_eff;

   // Subtraction is A + ~B + 1; the +1 arrives as the carry-in of the first chunk.
   always_comb begin
      b_eff = (alu_op_e'(op) == ALU_SUB) ? ~b : b;
      sum   = {1'b0, a} + {1'b0, b_eff} + {{CHUNK_W{1'b0}}, cin};
      res   = sum[CHUNK_W-1:0];
      cout  = sum[CHUNK_W];
      case (alu_op_e'(op))
         ALU_AND: begin
            res  = a & b;
            cout = 1'b0;
         end
         ALU_OR: begin
            res  = a | b;
            cout = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/rv32_alu_multicycle_unit.sv
// rtl/rv32_alu_multicycle_unit.sv - chunked multicycle ALU with valid/hold handshake
// Purpose: accepts an operand pair and op in IDLE, computes the result one
//          CHUNK_W slice per cycle, then holds it with o_data_valid high until
//          i_stall_reset drops.
// Ports:
//   i_clk            clock, rising edge
//   i_rst            synchronous active-high reset
//   i_en_alu         request, sampled only in IDLE
//   i_operand_one    operand A (captured on acceptance)
//   i_operand_two    operand B (captured on acceptance)
//   i_alu_sel        op: 00 ADD, 01 SUB, 10 AND, 11 OR
//   i_stall_reset    high in DONE holds the result, low releases to IDLE
//   o_result         32-bit result (registered)
//   o_carry_out      carry / not-borrow flag (registered)
//   o_data_valid     result valid (registered)
module rv32_alu_multicycle_unit
   import rv32_alu_pkg::*;
#(
   parameter int CHUNK_W = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_en_alu,
   input  logic [31:0] i_operand_one,
   input  logic [31:0] i_operand_two,
   input  logic [1:0]  i_alu_sel,
   input  logic        i_stall_reset,
   output logic [31:0] o_result,
   output logic        o_carry_out,
   output logic        o_data_valid
);

   localparam int N_CHUNKS = XLEN / CHUNK_W;
   localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
   localparam logic [XLEN-1:0] SLICE_MASK = XLEN'((64'd1 << CHUNK_W) - 64'd1);

   alu_fsm_state_e state_q, state_d;

   logic [XLEN-1:0]    op_a_q, op_b_q;
   alu_op_e            op_q;
   logic [IDX_W-1:0]   idx_q;
   logic               carry_q;
   logic [XLEN-1:0]    result_q;
   logic               carry_out_q;
   logic               valid_q;

   logic [4:0]         slice_shift;
   logic [CHUNK_W-1:0] a_slice, b_slice, res_slice;
   logic               slice_cout;
   logic               last_chunk;

   // Slices are picked with shifts rather than indexed part-selects so the
   // same code works for every legal CHUNK_W, including a single 32-bit chunk.
   assign slice_shift = 5'(32'(idx_q) * 32'(CHUNK_W));
   assign a_slice     = CHUNK_W'(op_a_q >> slice_shift);
   assign b_slice     = CHUNK_W'(op_b_q >> slice_shift);
   assign last_chunk  = (idx_q == IDX_W'(N_CHUNKS - 1));

   rv32_alu_chunk_slice #(
      .CHUNK_W (CHUNK_W)
   ) u_slice (
      .a    (a_slice),
      .b    (b_slice),
      .op   (op_q),
      .cin  (carry_q),
      .res  (res_slice),
      .cout (slice_cout)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_en_alu)       state_d = COMPUTE;
         COMPUTE: if (last_chunk)     state_d = DONE;
         DONE:    if (!i_stall_reset) state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_q        <= ALU_ADD;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (i_en_alu) begin
                  op_a_q  <= i_operand_one;
                  op_b_q  <= i_operand_two;
                  op_q    <= alu_op_e'(i_alu_sel);
                  idx_q   <= '0;
                  carry_q <= (alu_op_e'(i_alu_sel) == ALU_SUB);
               end
            end
            COMPUTE: begin
               result_q <= (result_q & ~(SLICE_MASK << slice_shift))
                         | (XLEN'(res_slice) << slice_shift);
               carry_q  <= slice_cout;
               idx_q    <= idx_q + IDX_W'(1);
               // The visible flag only changes once the full-width carry is known.
               if (last_chunk) begin
                  carry_out_q <= slice_cout;
                  valid_q     <= 1'b1;
               end
            end
            DONE: begin
               if (!i_stall_reset) valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign o_result     = result_q;
   assign o_carry_out  = carry_out_q;
   assign o_data_valid = valid_q;

endmodule

// File: tb/tb_rv32_alu_multicycle_unit.sv
// tb/tb_rv32_alu_multicycle_unit.sv - directed self-checking bench for rv32_alu_multicycle_unit
module tb_rv32_alu_multicycle_unit;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_en_alu = 1'b0;
   logic [31:0] i_operand_one = '0;
   logic [31:0] i_operand_two = '0;
   logic [1:0]  i_alu_sel = 2'b00;
   logic        i_stall_reset = 1'b0;
   logic [31:0] o_result;
   logic        o_carry_out;
   logic        o_data_valid;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 i_clk = ~i_clk;

   rv32_alu_multicycle_unit #(.CHUNK_W(8)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_en_alu      (i_en_alu),
      .i_operand_one (i_operand_one),
      .i_operand_two (i_operand_two),
      .i_alu_sel     (i_alu_sel),
      .i_stall_reset (i_stall_reset),
      .o_result      (o_result),
      .o_carry_out   (o_carry_out),
      .o_data_valid  (o_data_valid)
   );

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Launches one request from IDLE, waits (bounded) for valid, returns what was
   // seen and the number of edges from acceptance to valid (-1 if it never came).
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel,
                         output logic [31:0] res, output logic cy, output int lat);
      i_operand_one = a;
      i_operand_two = b;
      i_alu_sel     = sel;
      i_en_alu      = 1'b1;
      tick();
      i_en_alu = 1'b0;
      lat = -1;
      res = 'x;
      cy  = 1'bx;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (o_data_valid) begin
            lat = c;
            res = o_result;
            cy  = o_carry_out;
            break;
         end
      end
      tick();
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      tick();
      tick();
      total_cnt++;
      if (o_result !== 32'h0) $display("FAIL reset_result: got %h want %h", o_result, 32'h0);
      else pass_cnt++;
      total_cnt++;
      if (o_carry_out !== 1'b0) $display("FAIL reset_carry: got %b want 0", o_carry_out);
      else pass_cnt++;
      total_cnt++;
      if (o_data_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_data_valid);
      else pass_cnt++;
      i_rst = 1'b0;
      tick();
   endtask

   task automatic test_add();
      logic [31:0] r;
      logic c;
      int l;
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 2'b00, r, c, l);
      total_cnt++;
      if (r !== 32'h0) $display("FAIL add_wrap_result: got %h want %h", r, 32'h0);
      else pass_cnt++;
      total_cnt++;
      if (c !== 1'b1) $display("FAIL add_wrap_carry: got %b want 1", c);
      else pass_cnt++;
      total_cnt++;
      if (l != 4) $display("FAIL add_latency: got %0d want 4", l);
      else pass_cnt++;
   endtask

   task automatic test_sub();
      logic [31:0] va [3] = '{32'd5, 32'd7, 32'h8000_0000};
      logic [31:0] vb [3] = '{32'd7, 32'd5, 32'h8000_0000};
      logic [31:0] er [3] = '{32'hFFFF_FFFE, 32'h0000_0002, 32'h0};
      logic        ec [3] = '{1'b0, 1'b1, 1'b1};
      logic [31:0] r;
      logic c;
      int l;
      for (int i = 0; i < 3; i++) begin
         run_op(va[i], vb[i], 2'b01, r, c, l);
         total_cnt++;
         if (r !== er[i]) $display("FAIL sub%0d_result: got %h want %h", i, r, er[i]);
         else pass_cnt++;
         total_cnt++;
         if (c !== ec[i]) $display("FAIL sub%0d_carry: got %b want %b", i, c, ec[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_logic();
      logic [31:0] r;
      logic c;
      int l;
      run_op(32'hF0F0_1234, 32'h0FF0_FFFF, 2'b10, r, c, l);
      total_cnt++;
      if (r !== 32'h00F0_1234) $display("FAIL and_result: got %h want %h", r, 32'h00F0_1234);
      else pass_cnt++;
      total_cnt++;
      if (c !== 1'b0) $display("FAIL and_carry: got %b want 0", c);
      else pass_cnt++;
      run_op(32'hF0F0_1234, 32'h0FF0_FFFF, 2'b11, r, c, l);
      total_cnt++;
      if (r !== 32'hFFF0_FFFF) $display("FAIL or_result: got %h want %h", r, 32'hFFF0_FFFF);
      else pass_cnt++;
      total_cnt++;
      if (c !== 1'b0) $display("FAIL or_carry: got %b want 0", c);
      else pass_cnt++;
   endtask

   // Inputs wiggle every cycle after acceptance; only captured values may matter.
   task automatic test_operand_change();
      int l = -1;
      logic [31:0] r = 'x;
      logic c = 1'bx;
      i_operand_one = 32'h1234_5678;
      i_operand_two = 32'h1111_1111;
      i_alu_sel     = 2'b00;
      i_en_alu      = 1'b1;
      tick();
      for (int k = 1; k <= 20; k++) begin
         i_operand_one = 32'hFFFF_0000 ^ (32'(k) * 32'h0101_0101);
         i_operand_two = 32'hDEAD_BEEF + 32'(k);
         i_alu_sel     = 2'(k);
         i_en_alu      = k[0];
         tick();
         if (o_data_valid) begin
            l = k;
            r = o_result;
            c = o_carry_out;
            break;
         end
      end
      i_en_alu = 1'b0;
      tick();
      total_cnt++;
      if (r !== 32'h2345_6789) $display("FAIL capture_result: got %h want %h", r, 32'h2345_6789);
      else pass_cnt++;
      total_cnt++;
      if (c !== 1'b0) $display("FAIL capture_carry: got %b want 0", c);
      else pass_cnt++;
      total_cnt++;
      if (l != 4) $display("FAIL capture_latency: got %0d want 4", l);
      else pass_cnt++;
   endtask

   task automatic test_stall();
      int l = -1;
      int bad = 0;
      logic [31:0] r;
      logic c;
      i_stall_reset = 1'b1;
      i_operand_one = 32'd7;
      i_operand_two = 32'd5;
      i_alu_sel     = 2'b01;
      i_en_alu      = 1'b1;
      tick();
      i_en_alu = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (o_data_valid) begin
            l = k;
            break;
         end
      end
      total_cnt++;
      if (l != 4) $display("FAIL stall_latency: got %0d want 4", l);
      else pass_cnt++;
      // Next request is already presented while stalled; stall must win.
      i_operand_one = 32'h10;
      i_operand_two = 32'h20;
      i_alu_sel     = 2'b00;
      i_en_alu      = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (o_data_valid !== 1'b1 || o_result !== 32'h2 || o_carry_out !== 1'b1) bad++;
      end
      total_cnt++;
      if (bad != 0) $display("FAIL stall_hold: got %0d unstable cycles want 0", bad);
      else pass_cnt++;
      i_stall_reset = 1'b0;
      tick();
      total_cnt++;
      if (o_data_valid !== 1'b0) $display("FAIL stall_release_valid: got %b want 0", o_data_valid);
      else pass_cnt++;
      // i_en_alu still high: this edge is the first IDLE acceptance.
      tick();
      i_en_alu = 1'b0;
      l = -1;
      r = 'x;
      c = 1'bx;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (o_data_valid) begin
            l = k;
            r = o_result;
            c = o_carry_out;
            break;
         end
      end
      tick();
      total_cnt++;
      if (l != 4) $display("FAIL next_req_latency: got %0d want 4", l);
      else pass_cnt++;
      total_cnt++;
      if (r !== 32'h30 || c !== 1'b0) $display("FAIL next_req_result: got %h/%b want %h/0", r, c, 32'h30);
      else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      logic [31:0] r;
      logic c;
      int l;
      i_operand_one = 32'hFFFF_FFFF;
      i_operand_two = 32'hFFFF_FFFF;
      i_alu_sel     = 2'b00;
      i_en_alu      = 1'b1;
      tick();
      i_en_alu = 1'b0;
      tick();
      tick();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      total_cnt++;
      if (o_result !== 32'h0 || o_carry_out !== 1'b0 || o_data_valid !== 1'b0)
         $display("FAIL midreset_outputs: got %h/%b/%b want 0/0/0", o_result, o_carry_out, o_data_valid);
      else pass_cnt++;
      run_op(32'd3, 32'd4, 2'b00, r, c, l);
      total_cnt++;
      if (r !== 32'd7 || c !== 1'b0) $display("FAIL post_reset_add: got %h/%b want %h/0", r, c, 32'd7);
      else pass_cnt++;
      total_cnt++;
      if (l != 4) $display("FAIL post_reset_latency: got %0d want 4", l);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_operand_change();
      test_stall();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/rv32_alu_multicycle_unit.md
# rv32_alu_multicycle_unit

Multicycle responder for the core's ALU request/valid handshake: accepts an enable-qualified operand pair and operation select, computes the result over several cycles one chunk at a time, then raises a data-valid flag. It holds the result until the requester releases it. It sits in the execute stage of the multicycle RV32 datapath, driven by the execute-stage controller or by a bench wrapper.

## Interface
- CHUNK_W, 8, bits processed per compute cycle; must divide 32 (legal: 4, 8, 16, 32)
- N_CHUNKS, 32/CHUNK_W, derived localparam; number of compute cycles
- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  synchronous active-high reset
- i_en_alu  input  1  request; sampled only in IDLE
- i_operand_one  input  32  operand A, captured at request acceptance
- i_operand_two  input  32  operand B, captured at request acceptance
- i_alu_sel  input  2  operation, captured at acceptance: 00 ADD, 01 SUB, 10 AND, 11 OR
- i_stall_reset  input  1  while high in DONE, hold result/valid; low releases to IDLE
- o_result  output  32  result, registered
- o_carry_out  output  1  carry flag, registered
- o_data_valid  output  1  result valid, registered

## Operation
- States: IDLE, COMPUTE, DONE.
- IDLE: when i_en_alu=1, capture operands and select, set chunk index=0, set carry-in (ADD: 0, SUB: 1), go to COMPUTE. Otherwise stay.
- COMPUTE:
  - Each cycle, process slice [k*CHUNK_W +: CHUNK_W].
  - ADD: A+B+c. SUB: A+~B+c. AND/OR: bitwise, carry forced 0.
  - Write the slice into the result register and update the carry register.
  - After chunk N_CHUNKS-1, go to DONE.
- DONE:
  - o_data_valid=1. o_result and o_carry_out are stable.
  - i_stall_reset=1: stay.
  - i_stall_reset=0: go to IDLE next edge.
- Arithmetic is modulo 2^32.
  - ADD o_carry_out = carry out of bit 31.
  - SUB o_carry_out = NOT borrow, i.e. 1 when A>=B unsigned.
  - AND/OR o_carry_out = 0.
- The datapath never reads the live operand inputs after capture. Changes to them during COMPUTE/DONE are ignored.
- i_en_alu is ignored in COMPUTE and DONE. No queuing.
- o_result retains its last value in IDLE until the next capture overwrites it slice by slice. o_result is not meaningful while o_data_valid=0.

## Timing
- Reset values:
  - State: IDLE.
  - o_result=0, o_carry_out=0, o_data_valid=0.
  - Chunk index=0, internal operand/carry registers=0.
- Reset has priority over every transition, including mid-COMPUTE and in DONE. Outputs reach reset values after the reset edge.
- Latency: request accepted at edge E. Chunks are processed at edges E+1..E+N_CHUNKS. o_data_valid is high from edge E+N_CHUNKS (4 cycles for CHUNK_W=8).
- o_data_valid deasserts on the edge after i_stall_reset is sampled low in DONE.
- Earliest next acceptance is the following edge (IDLE with i_en_alu=1). Minimum request-to-request spacing is N_CHUNKS+2 cycles.
- i_en_alu and i_stall_reset high simultaneously in DONE: stall wins, no new capture.
- i_en_alu held high continuously: a new capture occurs on the first IDLE cycle after release.
- CHUNK_W=32: single compute cycle, valid at E+1.

## Structure
- Package rv32_alu_pkg holds:
  - alu_op_e: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11.
  - alu_fsm_state_e: IDLE, COMPUTE, DONE.
  - XLEN=32.
- Sub-module rv32_alu_chunk_slice is purely combinational. It takes CHUNK_W slices of A and B, the op, and carry-in. It returns the result slice and carry-out. The top instantiates one and muxes slices by chunk index.
- State and datapath registers live in the top. All outputs are driven straight from flops.

## Test plan
- ADD 0xFFFF_FFFF + 0x0000_0001 -> o_result=0x0000_0000, o_carry_out=1; o_data_valid rises exactly 4 cycles after acceptance.
- SUB 5 - 7 -> 0xFFFF_FFFE, carry 0. SUB 7 - 5 -> 0x0000_0002, carry 1. SUB 0x8000_0000 - 0x8000_0000 -> 0, carry 1.
- AND 0xF0F0_1234 & 0x0FF0_FFFF -> 0x00F0_1234. OR the same operands -> 0xFFF0_FFFF. Carry 0 for both.
- Operands and i_alu_sel changed every cycle during COMPUTE -> result equals the op on the captured values. Pulse i_en_alu during COMPUTE -> no restart, latency unchanged.
- i_stall_reset held high 10 cycles in DONE -> valid and result stable throughout. Drop it -> valid low next edge. A request on the next IDLE cycle completes normally.
- Assert i_rst after 2 compute cycles -> next cycle all outputs 0 and state IDLE. A subsequent ADD 3+4 -> 7, carry 0.
